gf_digit_collector: RTL and testbench
=====================================

# gf_digit_collector

Receive-side block for the digit-serial systolic GF(2^M) multiplier. It accepts the product as a stream of D-bit digits, most significant digit first, from the last systolic cell. It assembles M/D digits into one M-bit field element and presents it to the downstream consumer under a valid/ready handshake. One word can be assembled while the previous word waits at the output.

## Interface
Parameters:
- M, 16, field element width in bits
- D, 4, digit width in bits; M must be an integer multiple of D, and D < M

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset: asynchronous, active-high
- din  in  [1:D]  incoming digit; bit 1 is the MSB
- din_valid  in  1  din carries a digit this cycle
- din_ready  out  1  collector accepts a digit this cycle
- q  out  [1:M]  assembled field element; bit 1 is the MSB
- q_valid  out  1  q holds an unconsumed word
- q_ready  in  1  consumer takes q this cycle
- err  out  1  sticky protocol-error flag; present only with GF_COLLECT_ERR_EN

## Operation
- N = M/D digits make one word. A digit is accepted when din_valid && din_ready.
- Assembly register asm[1:M-D] plus digit counter cnt, range 0..N-1.
  - Each accepted digit with cnt < N-1 shifts into asm from the LSB end, then cnt increments.
  - After N-1 accepted digits, the first digit sits in asm[1:D].
- Last digit: an accepted digit with cnt == N-1 does three things on the same edge:
  - loads q <= {asm, din};
  - sets q_valid = 1;
  - clears cnt to 0.
- Output consumption: when q_valid && q_ready and no word completes on that edge, q_valid clears. q keeps its last value.
- Backpressure: din_ready = !(cnt == N-1 && q_valid && !q_ready). This is combinational from q_ready.
  - Digits 0..N-2 of the next word are always accepted.
  - Only the completing digit stalls while the output is occupied.
- Simultaneous completion and consumption: if the last digit is accepted on the same edge as q_valid && q_ready, q reloads with the new word and q_valid stays 1. This sustains full throughput with no bubble.
- Gaps: din_valid may drop at any point. Partial words are held indefinitely.
- Reset, including mid-word:
  - cnt = 0, asm = 0, q = 0, q_valid = 0;
  - err = 0 when present.
  - din_ready reads 1 during reset; digits presented during reset are discarded.
- A partial word in progress when reset asserts is lost. No word is emitted for it.

## Timing
- Throughput: one digit per cycle, i.e. one word per N cycles when unstalled.
- Latency: q_valid rises directly after the edge that accepts the last digit, i.e. 0 cycles of extra register delay.
- From first digit to q_valid: N edges.
- q and q_valid are registered outputs. din_ready depends combinationally on q_ready and registered state only, never on din_valid.
- Once q_valid is high, q must not change until it is consumed.

## Configuration
- GF_COLLECT_ERR_EN defined: adds the err output port.
  - err sets when din_valid && !din_ready, meaning the upstream systolic array overran the collector, which cannot throttle.
  - err stays set until rst.
  - The offending digit is dropped and cnt is unchanged.
- Undefined: no err port and no error logic. An overrun digit is silently dropped, with identical data-path behaviour.

## Structure
- Shared package gf_pkg holds:
  - field width M and digit width D defaults;
  - the derived constant N = M/D and the counter width clog2(N);
  - the MSB-first digit ordering constant shared with the serializer that feeds the array.
- One natural sub-module: gf_digit_shift, the D-bit-stride shift register with a load-enable. The counter and handshake logic remain in the top level.
- Reuse the existing delay register cell style for the q register: async reset, q cleared to 0.

## Test plan
All scenarios use M=16, D=4.
- Basic assembly: after reset, digits 0xA, 0xB, 0xC, 0xD on 4 consecutive cycles with q_ready=1 -> q=0xABCD and q_valid=1 after the 4th edge, then q_valid=0 one edge later.
- Back-to-back: 8 continuous digits 1..8 with q_ready=1 -> q=0x1234 then q=0x5678 four edges later. din_ready stays 1 throughout.
- Backpressure:
  - word 0x1111 is held with q_ready=0 while 0x2, 0x2, 0x2 are accepted;
  - din_ready drops before the 4th digit;
  - raising q_ready -> 0x2222 loads on that same edge and q_valid stays 1.
- Reset mid-word: assert rst after 2 digits (0xF, 0xE), release, then send 0x3, 0x4, 0x5, 0x6 -> q=0x3456. No word containing 0xF or 0xE appears.
- Gapped input: digits 0x9, 0x8, 0x7, 0x6 separated by 3 idle cycles each -> q=0x9876, and q_valid is asserted only after the 4th digit.
- With GF_COLLECT_ERR_EN: din_valid=1 while din_ready=0 -> err=1 persists until rst, and the held q is unchanged.

Source files
------------

// File: rtl/gf_pkg.sv
// Shared constants for the digit-serial GF(2^M) multiplier datapath.
package gf_pkg;
    localparam int GF_M = 16;
    localparam int GF_D = 4;
    localparam int GF_N = GF_M / GF_D;
    localparam int GF_CNT_W = $clog2(GF_N);
    // Digits travel most significant first, matching the serializer feeding the array.
    localparam bit GF_MSB_FIRST = 1'b1;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/gf_digit_shift.sv
// D-bit-stride shift register: each enabled edge shifts din in at the LSB end.
module gf_digit_shift #(
    parameter int W = 12,
    parameter int D = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:D] din,
    output logic [1:W] q
);
    generate
        if (W == D) begin : g_single
            always_ff @(posedge clk or posedge rst) begin
                if (rst)     q <= '0;
                else if (en) q <= din;
            end
        end else begin : g_multi
            always_ff @(posedge clk or posedge rst) begin
                if (rst)     q <= '0;
                else if (en) q <= {q[D+1:W], din};
            end
        end
    endgenerate
endmodule

// File: rtl/gf_digit_collector.sv
// Collects N = M/D MSB-first digits into one M-bit word behind a valid/ready output.
// Optional sticky overrun flag `err` is built when GF_COLLECT_ERR_EN is defined.
module gf_digit_collector
    import gf_pkg::*;
#(
    parameter int M = GF_M,
    parameter int D = GF_D
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:D] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [1:M] q,
    output logic       q_valid,
    input  logic       q_ready
`ifdef GF_COLLECT_ERR_EN
    ,
    output logic       err
`endif
);
    localparam int N  = M / D;
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] cnt;
    logic [1:M-D]  asm_r;
    logic          last, accept, shift_en;

    assign last      = (cnt == LAST);
    // Only the completing digit can stall; earlier digits fill the assembly register freely.
    assign din_ready = !(last && q_valid && !q_ready);
    assign accept    = din_valid && din_ready;
    assign shift_en  = accept && !last;

    gf_digit_shift #(.W(M - D), .D(D)) u_shift (
        .clk (clk),
        .rst (rst),
        .en  (shift_en),
        .din (din),
        .q   (asm_r)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         cnt <= '0;
        else if (accept) cnt <= last ? '0 : cnt + 1'b1;
    end

    // Completion wins over consumption so back-to-back words leave no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else if (accept && last) begin
            q       <= {asm_r, din};
            q_valid <= 1'b1;
        end else if (q_ready) begin
            q_valid <= 1'b0;
        end
    end

`ifdef GF_COLLECT_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          err <= 1'b0;
        else if (din_valid && !din_ready) err <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_gf_digit_collector.sv
// Scoreboard bench for gf_digit_collector (M=16, D=4) against a digit-queue reference model.
module tb_gf_digit_collector;
    localparam int M = 16;
    localparam int D = 4;
    localparam int N = M / D;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:D]   din = '0;
    logic         din_valid = 1'b0;
    logic         din_ready;
    logic [1:M]   q;
    logic         q_valid;
    logic         q_ready = 1'b0;
`ifdef GF_COLLECT_ERR_EN
    logic         err;
`endif

    int checks = 0;
    int errors = 0;

    gf_digit_collector #(.M(M), .D(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .q         (q),
        .q_valid   (q_valid),
        .q_ready   (q_ready)
`ifdef GF_COLLECT_ERR_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: digits of the word in progress, words awaiting consumption,
    // whether the output slot is occupied, and the sticky overrun flag.
    int unsigned part[$];
    logic [M-1:0] sb[$];
    bit out_full = 0;
    bit err_exp = 0;

    function automatic bit model_ready();
        return !(part.size() == N - 1 && out_full && !q_ready);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            part.delete();
            sb.delete();
            out_full = 0;
            err_exp  = 0;
        end else begin
            bit rdy, done;
            rdy  = model_ready();
            done = 0;
            if (din_valid && !rdy) err_exp = 1;
            if (din_valid && rdy) begin
                part.push_back(int'(din));
                if (part.size() == N) begin
                    logic [M-1:0] w;
                    w = '0;
                    foreach (part[i]) w = (w << D) | M'(part[i]);
                    sb.push_back(w);
                    part.delete();
                    done = 1;
                end
            end
            if (done)         out_full = 1;
            else if (q_ready) out_full = 0;
        end
    end

    // Monitor: compare outputs mid-cycle, pop the scoreboard on each handshake.
    bit hold_prev = 0;
    logic [M-1:0] held_q;
    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 0;
        end else begin
            chk("din_ready", 32'(din_ready), 32'(model_ready()));
            chk("q_valid", 32'(q_valid), 32'(out_full));
`ifdef GF_COLLECT_ERR_EN
            chk("err", 32'(err), 32'(err_exp));
`endif
            if (hold_prev) chk("q_stable", 32'(q), 32'(held_q));
            if (q_valid && q_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL q_unexpected: got 0x%0h expected no word at %0t", q, $time);
                end else begin
                    chk("q_word", 32'(q), 32'(sb.pop_front()));
                end
            end
            hold_prev = q_valid && !q_ready;
            held_q    = q;
        end
    end

    task automatic drive(input logic v, input logic [3:0] d, input logic r);
        din_valid = v;
        din       = d;
        q_ready   = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'h0, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        din_valid = 1'b1;   // digits offered during reset must be discarded
        din = 4'h7;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_q_valid", 32'(q_valid), 32'h0);
        chk("rst_din_ready", 32'(din_ready), 32'h1);
        din_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic assembly
        drive(1, 4'hA, 1); drive(1, 4'hB, 1); drive(1, 4'hC, 1); drive(1, 4'hD, 1);
        chk("basic_q", 32'(q), 32'hABCD);
        chk("basic_vld", 32'(q_valid), 32'h1);
        idle(1);
        chk("basic_vld_clr", 32'(q_valid), 32'h0);
        idle(2);

        // Back-to-back
        for (int i = 1; i <= 8; i++) drive(1, 4'(i), 1);
        chk("b2b_q", 32'(q), 32'h5678);
        idle(3);

        // Backpressure: hold 0x1111, queue three 0x2 digits, stall the fourth
        for (int i = 0; i < 3; i++) drive(1, 4'h1, 1);
        drive(1, 4'h1, 0);
        for (int i = 0; i < 3; i++) drive(1, 4'h2, 0);
        q_ready = 1'b0;
        #1;
        chk("bp_ready_low", 32'(din_ready), 32'h0);
        drive(1, 4'h2, 0);   // overrun: dropped
        chk("bp_held_q", 32'(q), 32'h1111);
        drive(1, 4'h2, 1);   // completes 0x2222 as 0x1111 is taken
        chk("bp_new_q", 32'(q), 32'h2222);
        chk("bp_vld_kept", 32'(q_valid), 32'h1);
        idle(3);

        // Reset mid-word
        drive(1, 4'hF, 1); drive(1, 4'hE, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
`ifdef GF_COLLECT_ERR_EN
        chk("err_cleared", 32'(err), 32'h0);
`endif
        drive(1, 4'h3, 1); drive(1, 4'h4, 1); drive(1, 4'h5, 1); drive(1, 4'h6, 1);
        chk("rstmid_q", 32'(q), 32'h3456);
        idle(2);

        // Gapped input
        drive(1, 4'h9, 1); idle(3);
        drive(1, 4'h8, 1); idle(3);
        drive(1, 4'h7, 1); idle(3);
        chk("gap_no_vld", 32'(q_valid), 32'h0);
        drive(1, 4'h6, 1);
        chk("gap_q", 32'(q), 32'h9876);
        idle(2);

        // Randomized traffic with a reset dropped in mid-run
        for (int c = 0; c < 400; c++) begin
            if (c == 200) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
            drive(logic'($urandom_range(0, 3) != 0), 4'($urandom), logic'($urandom_range(0, 1)));
        end

        idle(6);
        chk("drain_empty", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
